// File: rtl/crypto_pipe_ctrl.sv
// Sequencing controller for a three-stage crypto pipeline: job latch, stage strobes, result capture.
// Optional done-wait watchdog enabled by defining CRYPTO_CTRL_TIMEOUT_EN.
module crypto_pipe_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int S3_LAT         = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [4:0]  in_key,
  output logic        ld,
  output logic        start,
  output logic [15:0] stg_data,
  output logic [4:0]  stg_key,
  input  logic        stg1_done,
  input  logic        stg2_done,
  input  logic [15:0] stg3_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        err,
  input  logic        err_clr,
  output logic [7:0]  jobs_done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, S1_WAIT, S2_WAIT, S3_CAP, OUT_HOLD, ERR
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] stg_data_reg;
  logic [4:0]  stg_key_reg;
  logic [15:0] out_data_reg;
  logic [7:0]  jobs_done_reg;
  logic [3:0]  lat_cnt_reg;

`ifdef CRYPTO_CTRL_TIMEOUT_EN
  logic [7:0]  wait_cnt_reg;
  logic        err_reg;
  logic        wait_expired;

  assign wait_expired = (wait_cnt_reg == 8'(TIMEOUT_CYCLES - 1));
`else
  logic        unused_cfg;

  // Watchdog is compiled out; keep the otherwise-unused inputs visibly consumed.
  assign unused_cfg = (TIMEOUT_CYCLES > 0) ^ err_clr;
`endif

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    ld         = 1'b0;
    start      = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = LOAD;
      end
      LOAD: begin
        ld         = 1'b1;
        start      = 1'b1;
        state_next = S1_WAIT;
      end
      S1_WAIT: begin
        if (stg1_done) state_next = S2_WAIT;
`ifdef CRYPTO_CTRL_TIMEOUT_EN
        else if (wait_expired) state_next = ERR;
`endif
      end
      S2_WAIT: begin
        if (stg2_done) state_next = S3_CAP;
`ifdef CRYPTO_CTRL_TIMEOUT_EN
        else if (wait_expired) state_next = ERR;
`endif
      end
      S3_CAP: begin
        if (lat_cnt_reg == 4'd0) state_next = OUT_HOLD;
      end
      OUT_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      ERR: begin
`ifdef CRYPTO_CTRL_TIMEOUT_EN
        if (err_clr) state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      stg_data_reg  <= '0;
      stg_key_reg   <= '0;
      out_data_reg  <= '0;
      jobs_done_reg <= '0;
      lat_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && in_valid) begin
        stg_data_reg <= in_data;
        stg_key_reg  <= in_key;
      end
      // Counter reaching zero marks the cycle where stage-3 data is valid.
      if (state_reg == S2_WAIT && state_next == S3_CAP)
        lat_cnt_reg <= 4'(S3_LAT - 1);
      else if (state_reg == S3_CAP && lat_cnt_reg != 4'd0)
        lat_cnt_reg <= lat_cnt_reg - 4'd1;
      if (state_reg == S3_CAP && lat_cnt_reg == 4'd0)
        out_data_reg <= stg3_data;
      if (state_reg == OUT_HOLD && out_ready)
        jobs_done_reg <= jobs_done_reg + 8'd1;
    end
  end

`ifdef CRYPTO_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      // Any state change restarts the wait window, so each wait state gets a fresh budget.
      if (state_next != state_reg)
        wait_cnt_reg <= '0;
      else if (state_reg == S1_WAIT || state_reg == S2_WAIT)
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      if (state_reg == ERR && err_clr)
        err_reg <= 1'b0;
      else if (state_next == ERR && state_reg != ERR)
        err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign stg_data  = stg_data_reg;
  assign stg_key   = stg_key_reg;
  assign out_data  = out_data_reg;
  assign jobs_done = jobs_done_reg;

endmodule

// File: tb/tb_crypto_pipe_ctrl.sv
// Directed bench for crypto_pipe_ctrl: reset, abort, watchdog, jobs with backpressure and counter wrap.
// Expected results come from a scoreboard queue filled when each job is issued.
module tb_crypto_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, ld, start, stg1_done, stg2_done;
  logic        out_valid, out_ready, busy, err, err_clr;
  logic [15:0] in_data, stg_data, stg3_data, out_data;
  logic [4:0]  in_key, stg_key;
  logic [7:0]  jobs_done;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] sb[$];
  logic [7:0]  exp_jobs;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crypto_pipe_ctrl #(.TIMEOUT_CYCLES(8), .S3_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .ld(ld), .start(start), .stg_data(stg_data), .stg_key(stg_key),
    .stg1_done(stg1_done), .stg2_done(stg2_done), .stg3_data(stg3_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err), .err_clr(err_clr), .jobs_done(jobs_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] model(input logic [15:0] d, input logic [4:0] k);
    return {d[7:0], d[15:8]} ^ {k, k, k, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [15:0] d, input logic [4:0] k, input int d1, input int d2,
                         input int hold, input bit spur, input bit quiet);
    int          t0;
    int          lat;
    int          budget;
    logic [15:0] expv;
    logic [15:0] got;
    bit          ok;
    expv = model(d, k);
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = d; in_key = k;
    t0 = cyc;
    sb.push_back(expv);
    tick();
    in_valid = 1'b0; in_data = 16'hFFFF; in_key = 5'h1F;
    if (!quiet) check("load_strobe", {30'd0, ld, start}, 32'd3);
    tick();
    if (!quiet) check("strobe_clear", {29'd0, ld, start, in_ready}, 32'd0);
    if (spur) begin
      stg2_done = 1'b1; tick(); stg2_done = 1'b0;
    end
    repeat (d1) tick();
    stg1_done = 1'b1; tick(); stg1_done = 1'b0;
    repeat (d2) tick();
    stg2_done = 1'b1; tick(); stg2_done = 1'b0;
    stg3_data = expv;
    budget = 0;
    while (!out_valid && budget < 50) begin
      tick();
      budget++;
    end
    lat = cyc - t0;
    stg3_data = 16'hDEAD;
    check("out_valid_seen", {31'd0, out_valid}, 32'd1);
    if (!quiet) check("latency", 32'(lat), 32'(5 + d1 + d2 + int'(spur)));
    if (!quiet) check("stg_hold", {11'd0, stg_key, stg_data}, {11'd0, k, d});
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_data = 16'h1234; in_key = 5'h02;
      ok &= out_valid && (out_data == expv) && !in_ready && (stg_data == d) && (stg_key == k);
      tick();
    end
    in_valid = 1'b0;
    if (hold > 0) check("backpressure", {31'd0, ok}, 32'd1);
    got = sb.pop_front();
    check("out_data", {16'd0, out_data}, {16'd0, got});
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    exp_jobs = exp_jobs + 8'd1;
    check("jobs_done", {24'd0, jobs_done}, {24'd0, exp_jobs});
    if (!quiet) begin
      check("back_to_idle", {29'd0, busy, out_valid, in_ready}, 32'd1);
      check("out_data_retained", {16'd0, out_data}, {16'd0, expv});
    end
    $display("job data=%h key=%h out=%h lat=%0d jobs_done=%0d", d, k, out_data, lat, jobs_done);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit ok;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; stg1_done = 1'b0; stg2_done = 1'b0;
    stg3_data = 16'hDEAD; out_ready = 1'b0; err_clr = 1'b0; exp_jobs = 8'd0;
    tick(); tick();
    check("rst_ctrl", {26'd0, in_ready, ld, start, out_valid, busy, err}, 32'h20);
    check("rst_data", {11'd0, stg_key, stg_data}, 32'd0);
    check("rst_out", {8'd0, jobs_done, out_data}, 32'd0);
    rst = 1'b0;
    tick();

    // Reset asserted mid-job while in S2_WAIT.
    in_valid = 1'b1; in_data = 16'h5555; in_key = 5'h0A;
    tick(); in_valid = 1'b0;
    tick();
    stg1_done = 1'b1; tick(); stg1_done = 1'b0;
    check("s2_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 check("async_rst", {29'd0, busy, in_ready, out_valid}, 32'd2);
    check("async_rst_jobs", {24'd0, jobs_done}, 32'd0);
    tick(); rst = 1'b0;
    stg2_done = 1'b1; tick(); stg2_done = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ok &= !out_valid && !busy;
      tick();
    end
    check("abort_no_output", {31'd0, ok}, 32'd1);
    check("abort_jobs", {24'd0, jobs_done}, 32'd0);
    $display("reset mid-job: busy=%0b jobs_done=%0d", busy, jobs_done);

    // Withheld stg1_done: watchdog behaviour depends on the build.
    in_valid = 1'b1; in_data = 16'h0F0F; in_key = 5'h03;
    tick(); in_valid = 1'b0;
    tick();
`ifdef CRYPTO_CTRL_TIMEOUT_EN
    repeat (7) tick();
    check("err_before_limit", {31'd0, err}, 32'd0);
    tick();
    check("err_state", {28'd0, err, busy, in_ready, out_valid}, 32'hC);
    repeat (3) tick();
    check("err_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_cleared", {29'd0, err, busy, in_ready}, 32'd1);
    check("err_jobs", {24'd0, jobs_done}, 32'd0);
`else
    repeat (12) tick();
    check("no_watchdog", {29'd0, err, busy, in_ready}, 32'd2);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_clr_ignored", {29'd0, err, busy, in_ready}, 32'd2);
    rst = 1'b1; tick(); rst = 1'b0; tick();
`endif
    $display("timeout test: err=%0b busy=%0b", err, busy);

    run_job(16'hA5A5, 5'h13, 1, 1, 0, 1'b0, 1'b0);
    run_job(16'h3C3C, 5'h07, 0, 0, 10, 1'b0, 1'b0);
    run_job(16'hBEEF, 5'h1F, 2, 0, 0, 1'b1, 1'b0);
    for (int j = 0; j < 256; j++)
      run_job(16'($urandom), 5'($urandom), 0, 0, 0, 1'b0, 1'b1);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
